meta_downsizer: RTL and testbench

// - Serialises one wide metaIntf word into N_BEATS narrow metaIntf beats, LSB slice first.
// - Sits on the transmit side of a narrow meta channel, e.g. a 96b request crossing a 32b link.
// - The matching upsizer at the far end reassembles words by counting beats; there is no per-beat last flag.
// - Output is fully registered and streams beats back-to-back with no bubble between input words.
//

---
 rtl/meta_downsizer_pkg.sv | 22 ++
 rtl/meta_downsizer_if.sv | 11 +
 rtl/meta_downsizer.sv | 94 +++++++++
 tb/tb_meta_downsizer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/meta_downsizer_pkg.sv
// Shared definitions for the meta channel downsizer: state encoding and
// width arithmetic used to derive beat counts from the bus widths.
package meta_downsizer_pkg;

  localparam int DEF_IN_BITS  = 96;
  localparam int DEF_OUT_BITS = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ds_state_e;

  function automatic int beats_for(input int in_bits, input int out_bits);
    return (in_bits + out_bits - 1) / out_bits;
  endfunction

  // A single-beat configuration still needs a 1-bit counter to stay legal.
  function automatic int cnt_bits_for(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/meta_downsizer_if.sv
// valid/ready/data meta channel; m is the sending side, s the receiving side.
interface meta_downsizer_if #(
  parameter int DATA_BITS = 32
) ();
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  modport m (output valid, output data, input ready);
  modport s (input valid, input data, output ready);
endinterface

// File: rtl/meta_downsizer.sv
// Serialises one IN_BITS meta word into N_BEATS OUT_BITS beats, LSB slice first,
// with registered outputs and no bubble between consecutive words.
module meta_downsizer
  import meta_downsizer_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic          aclk,
  input  logic          aresetn,
  meta_downsizer_if.s   s_meta,
  meta_downsizer_if.m   m_meta
);

  localparam int N_BEATS   = beats_for(IN_BITS, OUT_BITS);
  localparam int CNT_BITS  = cnt_bits_for(N_BEATS);
  localparam int HOLD_BITS = N_BEATS * OUT_BITS;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(N_BEATS - 1);

  if (OUT_BITS > IN_BITS) begin : g_bad_width
    $error("meta_downsizer: OUT_BITS must not exceed IN_BITS");
  end

  ds_state_e              state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [HOLD_BITS-1:0]   hold_q, hold_d;
  logic [OUT_BITS-1:0]    data_q, data_d;
  logic [HOLD_BITS-1:0]   word_ext;
  logic                   s_rdy, s_fire, m_fire, load;

  // Zero-extension gives the padding of the final beat for free.
  assign word_ext = HOLD_BITS'(s_meta.data);

  // Ready combinationally follows m_meta.ready on the last beat so the next
  // word loads in the same cycle the last beat leaves.
  assign s_rdy  = aresetn && ((state_q == ST_IDLE) ||
                              (m_meta.ready && (cnt_q == CNT_LAST)));
  assign s_fire = s_meta.valid && s_rdy;
  assign m_fire = (state_q == ST_SEND) && m_meta.ready;

  assign s_meta.ready = s_rdy;
  assign m_meta.valid = (state_q == ST_SEND);
  assign m_meta.data  = data_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
    end
  end

  // hold_q keeps only the beats still to be sent after data_q, so advancing
  // is a plain shift rather than a variable slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    data_d  = data_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_fire) load = 1'b1;
      end
      ST_SEND: begin
        if (m_fire) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d  = cnt_q + CNT_BITS'(1);
            data_d = hold_q[OUT_BITS-1:0];
            hold_d = hold_q >> OUT_BITS;
          end else if (s_fire) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = ST_SEND;
      cnt_d   = '0;
      data_d  = word_ext[OUT_BITS-1:0];
      hold_d  = word_ext >> OUT_BITS;
    end
  end

endmodule

// File: tb/tb_meta_downsizer.sv
// Bench for meta_downsizer in three shapes (96->32, 40->32, 64->64) against a
// queue-of-expected-beats model, plus literal checks on directed cases.
module tb_meta_downsizer;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  localparam logic [95:0] W0 = 96'h0C0B0A09_08070605_04030201;
  localparam logic [95:0] W1 = 96'h33333333_22222222_11111111;
  localparam logic [95:0] W2 = 96'h66666666_55555555_44444444;

  meta_downsizer_if #(.DATA_BITS(96)) s0 ();
  meta_downsizer_if #(.DATA_BITS(32)) m0 ();
  meta_downsizer_if #(.DATA_BITS(40)) s1 ();
  meta_downsizer_if #(.DATA_BITS(32)) m1 ();
  meta_downsizer_if #(.DATA_BITS(64)) s2 ();
  meta_downsizer_if #(.DATA_BITS(64)) m2 ();

  meta_downsizer #(.IN_BITS(96), .OUT_BITS(32)) u_d96 (
    .aclk(aclk), .aresetn(aresetn), .s_meta(s0), .m_meta(m0));
  meta_downsizer #(.IN_BITS(40), .OUT_BITS(32)) u_d40 (
    .aclk(aclk), .aresetn(aresetn), .s_meta(s1), .m_meta(m1));
  meta_downsizer #(.IN_BITS(64), .OUT_BITS(64)) u_d64 (
    .aclk(aclk), .aresetn(aresetn), .s_meta(s2), .m_meta(m2));

  logic        sv [3];
  logic        mr [3];
  logic [95:0] sd [3];
  logic        sr [3];
  logic        mv [3];
  logic [63:0] md [3];

  assign s0.valid = sv[0];  assign s0.data = sd[0];         assign m0.ready = mr[0];
  assign s1.valid = sv[1];  assign s1.data = sd[1][39:0];   assign m1.ready = mr[1];
  assign s2.valid = sv[2];  assign s2.data = sd[2][63:0];   assign m2.ready = mr[2];
  assign sr[0] = s0.ready;  assign mv[0] = m0.valid;  assign md[0] = {32'h0, m0.data};
  assign sr[1] = s1.ready;  assign mv[1] = m1.valid;  assign md[1] = {32'h0, m1.data};
  assign sr[2] = s2.ready;  assign mv[2] = m2.valid;  assign md[2] = m2.data;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [63:0] q [3][$];

  function automatic int ib_of(input int ch);
    case (ch) 0: return 96; 1: return 40; default: return 64; endcase
  endfunction
  function automatic int ob_of(input int ch);
    return (ch == 2) ? 64 : 32;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beats of one word: the word cut into OUT_BITS slices from bit 0.
  task automatic push_word(input int ch, input logic [95:0] raw);
    logic [95:0] w;
    logic [63:0] b;
    int ib, ob, nb;
    ib = ib_of(ch);
    ob = ob_of(ch);
    nb = (ib + ob - 1) / ob;
    for (int i = 0; i < 96; i++) w[i] = (i < ib) ? raw[i] : 1'b0;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int j = 0; j < ob; j++) if (k * ob + j < 96) b[j] = w[k * ob + j];
      q[ch].push_back(b);
    end
  endtask

  // Model: the DUT holds the unsent beats of at most one word; a new word is
  // taken only when nothing is pending or the final pending beat leaves now.
  always @(negedge aclk) begin : cmp
    int  n;
    logic esr;
    if (chk_en) begin
      for (int ch = 0; ch < 3; ch++) begin
        n   = q[ch].size();
        esr = aresetn && ((n == 0) || ((n == 1) && mr[ch]));
        chk($sformatf("s_ready ch%0d", ch), {95'h0, sr[ch]}, {95'h0, esr});
        chk($sformatf("m_valid ch%0d", ch), {95'h0, mv[ch]}, {95'h0, (n > 0)});
        if (n > 0) chk($sformatf("m_data ch%0d", ch), {32'h0, md[ch]}, {32'h0, q[ch][0]});
        if (!aresetn) begin
          q[ch].delete();
        end else begin
          if ((n > 0) && mr[ch]) void'(q[ch].pop_front());
          if (sv[ch] && esr) push_word(ch, sd[ch]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic settle();
    @(negedge aclk);
  endtask

  function automatic logic [95:0] w64(input int i);
    return {32'h0, 32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i)};
  endfunction

  initial begin
    aresetn = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      sv[ch] = 1'b0;
      mr[ch] = 1'b1;
      sd[ch] = '0;
    end
    tick(); tick();
    chk_en = 1'b1;
    settle();
    for (int ch = 0; ch < 3; ch++) begin
      chk("rst m_valid", {95'h0, mv[ch]}, 96'h0);
      chk("rst m_data", {32'h0, md[ch]}, 96'h0);
      chk("rst s_ready", {95'h0, sr[ch]}, 96'h0);
    end
    tick(); aresetn = 1'b1;
    settle();
    chk("idle s_ready", {95'h0, sr[0]}, 96'h1);

    // 96->32 single word
    tick(); sv[0] = 1'b1; sd[0] = W0;
    tick(); sv[0] = 1'b0;
    settle(); chk("d96 beat0", {32'h0, md[0]}, 96'h04030201);
    chk("d96 sr mid0", {95'h0, sr[0]}, 96'h0);
    tick(); settle(); chk("d96 beat1", {32'h0, md[0]}, 96'h08070605);
    chk("d96 sr mid1", {95'h0, sr[0]}, 96'h0);
    tick(); settle(); chk("d96 beat2", {32'h0, md[0]}, 96'h0C0B0A09);
    chk("d96 sr last", {95'h0, sr[0]}, 96'h1);
    tick(); settle(); chk("d96 done", {95'h0, mv[0]}, 96'h0);

    // two words back to back: six beats with no gap
    tick(); sv[0] = 1'b1; sd[0] = W1;
    tick(); sd[0] = W2;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("b2b valid", {95'h0, mv[0]}, 96'h1);
      chk("b2b data", {32'h0, md[0]}, 96'(32'h11111111 * (i + 1)));
      tick();
      if (i == 2) sv[0] = 1'b0;
    end
    settle(); chk("b2b done", {95'h0, mv[0]}, 96'h0);

    // second beat stalled three cycles
    tick(); sv[0] = 1'b1; sd[0] = W0;
    tick(); sv[0] = 1'b0;
    settle();
    tick(); mr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall valid", {95'h0, mv[0]}, 96'h1);
      chk("stall data", {32'h0, md[0]}, 96'h08070605);
      tick();
    end
    mr[0] = 1'b1;
    settle(); chk("release data", {32'h0, md[0]}, 96'h08070605);
    tick(); settle(); chk("after release", {32'h0, md[0]}, 96'h0C0B0A09);
    tick(); settle(); chk("stall done", {95'h0, mv[0]}, 96'h0);

    // 40->32 padding
    tick(); sv[1] = 1'b1; sd[1] = 96'hAB_12345678;
    tick(); sv[1] = 1'b0;
    settle(); chk("d40 beat0", {32'h0, md[1]}, 96'h12345678);
    tick(); settle(); chk("d40 beat1", {32'h0, md[1]}, 96'h000000AB);
    tick(); settle(); chk("d40 done", {95'h0, mv[1]}, 96'h0);

    // reset after the first beat drops the rest of the word
    tick(); sv[0] = 1'b1; sd[0] = W0;
    tick(); sv[0] = 1'b0;
    settle();
    tick(); aresetn = 1'b0;
    settle(); chk("rst s_ready low", {95'h0, sr[0]}, 96'h0);
    tick(); aresetn = 1'b1;
    settle(); chk("post-rst valid", {95'h0, mv[0]}, 96'h0);
    tick(); sv[0] = 1'b1; sd[0] = W1;
    tick(); sv[0] = 1'b0;
    settle(); chk("post-rst beat0", {32'h0, md[0]}, 96'h11111111);
    tick(); tick(); tick();
    settle(); chk("post-rst done", {95'h0, mv[0]}, 96'h0);

    // 64->64 at one word per cycle
    tick(); sv[2] = 1'b1; sd[2] = w64(0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("d64 s_ready", {95'h0, sr[2]}, 96'h1);
      if (i > 0) begin
        chk("d64 valid", {95'h0, mv[2]}, 96'h1);
        chk("d64 data", {32'h0, md[2]}, w64(i - 1));
      end
      tick(); sd[2] = w64(i + 1);
    end
    sv[2] = 1'b0;
    tick(); tick();

    // randomized traffic with occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int ch = 0; ch < 3; ch++) begin
        sv[ch] = ($urandom_range(0, 2) != 0);
        mr[ch] = ($urandom_range(0, 3) != 0);
        sd[ch] = {$urandom, $urandom, $urandom};
      end
      aresetn = ($urandom_range(0, 299) != 0);
    end
    tick();
    aresetn = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      sv[ch] = 1'b0;
      mr[ch] = 1'b1;
    end
    for (int i = 0; i < 5; i++) tick();
    settle();
    for (int ch = 0; ch < 3; ch++) chk("drained", {95'h0, mv[ch]}, 96'h0);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
